tile_bank_response_merger: RTL and testbench

Return-path counterpart of the tile address decoder: gathers read responses coming back from the NUM_BANKS interleaved SRAM banks, restores original request order, and rebuilds the global address as {bank_offset, bank_select}. Requests are logged in issue order into a circular reorder buffer (ROB); banks answer out of order by tag. Responses leave in issue order toward the requesting core.

---
 rtl/tile_bank_response_merger.sv | 137 +++++++++++++
 tb/tb_tile_bank_response_merger.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_bank_response_merger.sv
// rtl/tile_bank_response_merger.sv - reorders tagged bank read responses back into issue order
// Optional same-cycle head bypass from a matching response: define GRIDX_MERGE_BYPASS_EN.
module tile_bank_response_merger #(
  parameter int ADDR_BITS   = 8,
  parameter int NUM_BANKS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int ROB_DEPTH   = 4,
  parameter int BANK_BITS   = $clog2(NUM_BANKS),
  parameter int OFFSET_BITS = ADDR_BITS - BANK_BITS,
  parameter int TAG_BITS    = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [BANK_BITS-1:0]           issue_bank,
  input  logic [OFFSET_BITS-1:0]         issue_offset,
  output logic [TAG_BITS-1:0]            issue_tag,
  input  logic [NUM_BANKS-1:0]           resp_valid,
  input  logic [NUM_BANKS*TAG_BITS-1:0]  resp_tag,
  input  logic [NUM_BANKS*DATA_BITS-1:0] resp_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_BITS-1:0]           out_address,
  output logic [DATA_BITS-1:0]           out_data,
  output logic [TAG_BITS:0]              occupancy,
  output logic                           spurious_resp
);

  typedef enum logic [1:0] {
    ENTRY_EMPTY,
    ENTRY_PENDING,
    ENTRY_DONE
  } entry_state_t;

  localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS + 1)'(ROB_DEPTH);

  entry_state_t           entry_state  [ROB_DEPTH];
  logic [BANK_BITS-1:0]   entry_bank   [ROB_DEPTH];
  logic [OFFSET_BITS-1:0] entry_offset [ROB_DEPTH];
  logic [DATA_BITS-1:0]   entry_data   [ROB_DEPTH];

  logic [TAG_BITS-1:0] head;
  logic [TAG_BITS-1:0] tail;
  logic [TAG_BITS:0]   count;
  logic                spurious_q;

  logic [ROB_DEPTH-1:0] hit;
  logic [DATA_BITS-1:0] hit_data [ROB_DEPTH];
  logic                 drop_any;
  logic                 head_done;
  logic                 issue_fire;
  logic                 pop;
  logic [DATA_BITS-1:0] head_data;

  // Banks are scanned in ascending order so the lowest bank claims a tag first;
  // any later hit on that tag, or on a non-PENDING entry, is dropped.
  always_comb begin
    hit      = '0;
    drop_any = 1'b0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      hit_data[e] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (resp_valid[b]) begin
        if (entry_state[resp_tag[b*TAG_BITS +: TAG_BITS]] == ENTRY_PENDING &&
            !hit[resp_tag[b*TAG_BITS +: TAG_BITS]]) begin
          hit[resp_tag[b*TAG_BITS +: TAG_BITS]]      = 1'b1;
          hit_data[resp_tag[b*TAG_BITS +: TAG_BITS]] = resp_data[b*DATA_BITS +: DATA_BITS];
        end else begin
          drop_any = 1'b1;
        end
      end
    end
  end

  assign head_done = (entry_state[head] == ENTRY_DONE);

`ifdef GRIDX_MERGE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = (entry_state[head] == ENTRY_PENDING) && hit[head];
  assign out_valid  = head_done || bypass_hit;
  assign head_data  = head_done ? entry_data[head] : hit_data[head];
`else
  assign out_valid  = head_done;
  assign head_data  = entry_data[head];
`endif

  assign out_data      = out_valid ? head_data : '0;
  assign out_address   = out_valid ? {entry_offset[head], entry_bank[head]} : '0;
  assign issue_ready   = (count < FULL_COUNT);
  assign issue_tag     = tail;
  assign occupancy     = count;
  assign spurious_resp = spurious_q;
  assign issue_fire    = issue_valid && issue_ready;
  assign pop           = out_valid && out_ready;

  // Pop is applied last so a bypassed head goes straight to EMPTY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      spurious_q <= 1'b0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        entry_state[e]  <= ENTRY_EMPTY;
        entry_bank[e]   <= '0;
        entry_offset[e] <= '0;
        entry_data[e]   <= '0;
      end
    end else begin
      spurious_q <= spurious_q | drop_any;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        if (hit[e]) begin
          entry_state[e] <= ENTRY_DONE;
          entry_data[e]  <= hit_data[e];
        end
      end
      if (issue_fire) begin
        entry_state[tail]  <= ENTRY_PENDING;
        entry_bank[tail]   <= issue_bank;
        entry_offset[tail] <= issue_offset;
        tail               <= tail + TAG_BITS'(1);
      end
      if (pop) begin
        entry_state[head] <= ENTRY_EMPTY;
        head              <= head + TAG_BITS'(1);
      end
      case ({issue_fire, pop})
        2'b10:   count <= count + (TAG_BITS + 1)'(1);
        2'b01:   count <= count - (TAG_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_bank_response_merger.sv
// tb/tb_tile_bank_response_merger.sv - directed and randomized bench for tile_bank_response_merger
module tb_tile_bank_response_merger;
  localparam int ADDR_BITS   = 8;
  localparam int NUM_BANKS   = 8;
  localparam int DATA_BITS   = 8;
  localparam int ROB_DEPTH   = 4;
  localparam int BANK_BITS   = 3;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = 2;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           issue_valid;
  logic                           issue_ready;
  logic [BANK_BITS-1:0]           issue_bank;
  logic [OFFSET_BITS-1:0]         issue_offset;
  logic [TAG_BITS-1:0]            issue_tag;
  logic [NUM_BANKS-1:0]           resp_valid;
  logic [NUM_BANKS*TAG_BITS-1:0]  resp_tag;
  logic [NUM_BANKS*DATA_BITS-1:0] resp_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [ADDR_BITS-1:0]           out_address;
  logic [DATA_BITS-1:0]           out_data;
  logic [TAG_BITS:0]              occupancy;
  logic                           spurious_resp;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int  addr;
    int  data;
    bit  done;
  } exp_t;

  exp_t mq[$];
  int   m_head;

  always #5 clk = ~clk;

  tile_bank_response_merger dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_bank(issue_bank), .issue_offset(issue_offset), .issue_tag(issue_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_address(out_address), .out_data(out_data),
    .occupancy(occupancy), .spurious_resp(spurious_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    resp_valid = '0;
    resp_tag   = '0;
    resp_data  = '0;
  endtask

  task automatic set_resp(input int bank, input int tag, input int data);
    resp_valid[bank] = 1'b1;
    resp_tag[bank*TAG_BITS +: TAG_BITS]   = TAG_BITS'(tag);
    resp_data[bank*DATA_BITS +: DATA_BITS] = DATA_BITS'(data);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    issue_valid = 1'b0;
    issue_bank = '0;
    issue_offset = '0;
    out_ready = 1'b0;
    clear_resp();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic issue_one(input int bank, input int off, input int exp_tag);
    issue_valid  = 1'b1;
    issue_bank   = BANK_BITS'(bank);
    issue_offset = OFFSET_BITS'(off);
    #1;
    chk("issue_tag", 32'(issue_tag), 32'(exp_tag));
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic respond(input int bank, input int tag, input int data);
    set_resp(bank, tag, data);
    tick();
    clear_resp();
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0;
    issue_bank = '0;
    issue_offset = '0;
    out_ready = 1'b0;
    clear_resp();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_address", 32'(out_address), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_issue_tag", 32'(issue_tag), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_spurious", 32'(spurious_resp), 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    tick();
    reset = 1'b1;

    // In-order pair
    issue_one(3, 5, 0);
    issue_one(4, 5, 1);
    set_resp(3, 0, 8'hA1);
    #1;
`ifndef GRIDX_MERGE_BYPASS_EN
    chk("inorder_latency", 32'(out_valid), 0);
`endif
    tick();
    clear_resp();
    #1;
    chk("inorder0_valid", 32'(out_valid), 1);
    chk("inorder0_addr", 32'(out_address), 32'h2B);
    chk("inorder0_data", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    set_resp(4, 1, 8'hB2);
    tick();
    clear_resp();
    #1;
    chk("inorder1_valid", 32'(out_valid), 1);
    chk("inorder1_addr", 32'(out_address), 32'h2C);
    chk("inorder1_data", 32'(out_data), 32'hB2);
    tick();
    out_ready = 1'b0;
    #1;
    chk("inorder_drained", 32'(out_valid), 0);
    chk("inorder_occ", 32'(occupancy), 0);

    // Reorder: responses 3,1,2 then 0
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(i, i + 8, i);
    #1;
    chk("full_ready", 32'(issue_ready), 0);
    chk("full_occ", 32'(occupancy), 4);
    respond(7, 3, 8'h33);
    #1 chk("reorder_wait3", 32'(out_valid), 0);
    respond(6, 1, 8'h31);
    #1 chk("reorder_wait1", 32'(out_valid), 0);
    respond(5, 2, 8'h32);
    #1 chk("reorder_wait2", 32'(out_valid), 0);
    respond(0, 0, 8'h30);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("reorder_valid", 32'(out_valid), 1);
      chk("reorder_addr", 32'(out_address), 32'(((i + 8) << 3) | i));
      chk("reorder_data", 32'(out_data), 32'(8'h30 + i));
      tick();
    end
    out_ready = 1'b0;
    #1 chk("reorder_occ", 32'(occupancy), 0);

    // Full, pop+issue same cycle refused, then wrap to tag 0
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(1, i, i);
    respond(1, 0, 8'h77);
    out_ready = 1'b1;
    issue_valid = 1'b1;
    issue_bank = 3'd2;
    issue_offset = 5'd9;
    #1;
    chk("wrap_refused", 32'(issue_ready), 0);
    chk("wrap_head_valid", 32'(out_valid), 1);
    tick();
    issue_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("wrap_occ3", 32'(occupancy), 3);
    chk("wrap_ready", 32'(issue_ready), 1);
    issue_one(2, 9, 0);
    #1 chk("wrap_occ4", 32'(occupancy), 4);

    // Collision on tag 1 between banks 2 and 5
    do_reset();
    issue_one(0, 1, 0);
    issue_one(0, 2, 1);
    set_resp(2, 1, 8'h22);
    set_resp(5, 1, 8'h55);
    tick();
    clear_resp();
    #1 chk("collision_spurious", 32'(spurious_resp), 1);
    respond(0, 0, 8'h11);
    out_ready = 1'b1;
    #1 chk("collision_head", 32'(out_data), 32'h11);
    tick();
    #1;
    chk("collision_winner", 32'(out_data), 32'h22);
    chk("collision_addr", 32'(out_address), 32'h10);
    tick();
    out_ready = 1'b0;

    // Response to an EMPTY tag
    do_reset();
    #1 chk("empty_pre", 32'(spurious_resp), 0);
    respond(3, 2, 8'h44);
    #1 chk("empty_spurious", 32'(spurious_resp), 1);

    // Backpressure hold
    do_reset();
    issue_one(5, 17, 0);
    respond(5, 0, 8'h9C);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_addr", 32'(out_address), 32'h8D);
      chk("bp_data", 32'(out_data), 32'h9C);
      chk("bp_occ", 32'(occupancy), 1);
      tick();
    end

    // Reset mid-flight, then a stale response
    do_reset();
    issue_one(1, 1, 0);
    issue_one(2, 2, 1);
    issue_one(3, 3, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_occ", 32'(occupancy), 0);
    chk("midrst_ready", 32'(issue_ready), 1);
    chk("midrst_tag", 32'(issue_tag), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_spurious", 32'(spurious_resp), 0);
    tick();
    reset = 1'b1;
    respond(2, 1, 8'h5A);
    #1 chk("stale_spurious", 32'(spurious_resp), 1);

    // Randomized run against an issue-order queue model
    do_reset();
    m_head = 0;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit exp_valid;
      bit taken [4];
      int rdat [4];
      bit do_issue;
      int ib, io;
      exp_valid = (mq.size() > 0) && mq[0].done;
      out_ready = ($urandom_range(0, 2) != 0);
      do_issue  = (mq.size() < ROB_DEPTH) && ($urandom_range(0, 1) == 1);
      ib = $urandom_range(0, NUM_BANKS - 1);
      io = $urandom_range(0, 31);
      issue_valid  = do_issue;
      issue_bank   = BANK_BITS'(ib);
      issue_offset = OFFSET_BITS'(io);
      for (int j = 0; j < 4; j++) begin
        taken[j] = 1'b0;
        rdat[j] = 0;
      end
      clear_resp();
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (mq.size() > 0 && $urandom_range(0, 3) == 0) begin
          int j;
          j = $urandom_range(0, mq.size() - 1);
          if (!mq[j].done && !taken[j]) begin
            taken[j] = 1'b1;
            rdat[j] = $urandom_range(0, 255);
            set_resp(b, (m_head + j) % ROB_DEPTH, rdat[j]);
          end
        end
      end
      #1;
      chk("rnd_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_addr", 32'(out_address), 32'(mq[0].addr));
        chk("rnd_data", 32'(out_data), 32'(mq[0].data));
      end
      chk("rnd_ready", 32'(issue_ready), 32'(mq.size() < ROB_DEPTH));
      chk("rnd_tag", 32'(issue_tag), 32'((m_head + mq.size()) % ROB_DEPTH));
      chk("rnd_occ", 32'(occupancy), 32'(mq.size()));
      chk("rnd_spurious", 32'(spurious_resp), 0);
      tick();
      for (int j = 0; j < 4; j++) begin
        if (taken[j]) begin
          mq[j].done = 1'b1;
          mq[j].data = rdat[j];
        end
      end
      if (exp_valid && out_ready) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % ROB_DEPTH;
      end
      if (do_issue) mq.push_back('{addr: (io << 3) | ib, data: 0, done: 1'b0});
      issue_valid = 1'b0;
      clear_resp();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
